// File: rtl/cgra_obi_resp_mem.sv
// cgra_obi_resp_mem: OBI responder serving word reads/writes into a word-addressed buffer.
// Ports: clk_i, rst_ni (sync, active-low), slave_req_i (OBI req), slave_resp_o (gnt/rvalid/rdata);
// with CGRA_OBI_RESP_STATS_EN defined also rd_cnt_o, wr_cnt_o, oor_cnt_o (granted transfer counters).
// Parameters: DEPTH (words), BASE_ADDR (byte address of word 0), GNT_WAIT (0..7), READ_LATENCY (1..4).

package cgra_obi_resp_mem_pkg;
    typedef struct packed {
        logic        req;
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } obi_req_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
    } obi_resp_t;
endpackage

module cgra_obi_resp_mem #(
    parameter type         obi_req_t    = cgra_obi_resp_mem_pkg::obi_req_t,
    parameter type         obi_resp_t   = cgra_obi_resp_mem_pkg::obi_resp_t,
    parameter int          DEPTH        = 256,
    parameter logic [31:0] BASE_ADDR    = 32'h0,
    parameter int          GNT_WAIT     = 0,
    parameter int          READ_LATENCY = 1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  obi_req_t    slave_req_i,
    output obi_resp_t   slave_resp_o
`ifdef CGRA_OBI_RESP_STATS_EN
    ,
    output logic [31:0] rd_cnt_o,
    output logic [31:0] wr_cnt_o,
    output logic [31:0] oor_cnt_o
`endif
);

    localparam int          AW       = $clog2(DEPTH);
    localparam logic [2:0]  WAIT_LD  = 3'(GNT_WAIT > 0 ? GNT_WAIT - 1 : 0);
    localparam logic [31:0] OOR_DATA = 32'hBADCAB1E;

    typedef enum logic {
        IDLE,
        WAIT
    } state_e;

    state_e      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        gnt;
    logic        xfer;

    // Grant FSM: with no wait states the grant is a straight echo of req.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gnt     = 1'b0;
        if (GNT_WAIT == 0) begin
            gnt = slave_req_i.req;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (slave_req_i.req) begin
                        cnt_d   = WAIT_LD;
                        state_d = WAIT;
                    end
                end
                WAIT: begin
                    if (!slave_req_i.req) begin
                        state_d = IDLE;
                    end else if (cnt_q != 3'd0) begin
                        cnt_d = cnt_q - 3'd1;
                    end else begin
                        gnt     = 1'b1;
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Reset masks the grant so nothing transfers while rst_ni is low.
    assign xfer = gnt & slave_req_i.req & rst_ni;

    // 33-bit subtract: the borrow flags addresses below BASE_ADDR.
    logic [32:0]   diff;
    logic          in_range;
    logic [AW-1:0] idx;
    logic          unused_addr_lsb;

    assign diff            = {1'b0, slave_req_i.addr} - {1'b0, BASE_ADDR};
    assign in_range        = !diff[32] && (diff[31:AW+2] == '0);
    assign idx             = diff[AW+1:2];
    assign unused_addr_lsb = ^diff[1:0];

    logic [31:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (xfer && slave_req_i.we && in_range) begin
            for (int i = 0; i < 4; i++) begin
                if (slave_req_i.be[i]) begin
                    mem_q[idx][8*i +: 8] <= slave_req_i.wdata[8*i +: 8];
                end
            end
        end
    end

    logic [31:0] rsp_data;

    always_comb begin
        rsp_data = '0;
        if (!slave_req_i.we) begin
            rsp_data = in_range ? mem_q[idx] : OOR_DATA;
        end
    end

    // Fixed-latency response pipe; OBI has no rready, so it never stalls.
    logic [READ_LATENCY-1:0] vld_q;
    logic [31:0]             dat_q [READ_LATENCY];

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            vld_q <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                dat_q[i] <= '0;
            end
        end else begin
            vld_q[0] <= xfer;
            dat_q[0] <= xfer ? rsp_data : '0;
            for (int i = 1; i < READ_LATENCY; i++) begin
                vld_q[i] <= vld_q[i-1];
                dat_q[i] <= dat_q[i-1];
            end
        end
    end

    logic rvalid;
    assign rvalid = vld_q[READ_LATENCY-1] & rst_ni;

    always_comb begin
        slave_resp_o        = '0;
        slave_resp_o.gnt    = gnt & rst_ni;
        slave_resp_o.rvalid = rvalid;
        slave_resp_o.rdata  = rvalid ? dat_q[READ_LATENCY-1] : '0;
    end

`ifdef CGRA_OBI_RESP_STATS_EN
    logic [31:0] rd_cnt_q, wr_cnt_q, oor_cnt_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rd_cnt_q  <= '0;
            wr_cnt_q  <= '0;
            oor_cnt_q <= '0;
        end else if (xfer) begin
            if (!in_range) begin
                oor_cnt_q <= oor_cnt_q + 32'd1;
            end else if (slave_req_i.we) begin
                wr_cnt_q <= wr_cnt_q + 32'd1;
            end else begin
                rd_cnt_q <= rd_cnt_q + 32'd1;
            end
        end
    end

    assign rd_cnt_o  = rd_cnt_q;
    assign wr_cnt_o  = wr_cnt_q;
    assign oor_cnt_o = oor_cnt_q;
`endif

endmodule

// File: tb/tb_cgra_obi_resp_mem.sv
// tb_cgra_obi_resp_mem: three responder configurations, each shadowed by a
// cycle-level reference model; table vectors, directed corner cases, random traffic.
module tb_cgra_obi_resp_mem;
    import cgra_obi_resp_mem_pkg::*;

    localparam int N = 3;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    obi_req_t  rq [N];
    obi_resp_t rs [N];
`ifdef CGRA_OBI_RESP_STATS_EN
    logic [31:0] rdc [N];
    logic [31:0] wrc [N];
    logic [31:0] ooc [N];
`endif

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] bmask(input logic [3:0] k);
        return {{8{k[3]}}, {8{k[2]}}, {8{k[1]}}, {8{k[0]}}};
    endfunction

    // u0: defaults; u1: wait states, base offset; u2: long latency, small depth
    for (genvar g = 0; g < N; g++) begin : inst
        localparam int          GW = (g == 1) ? 3 : 0;
        localparam int          RL = (g == 1) ? 2 : (g == 2) ? 3 : 1;
        localparam int          DP = (g == 0) ? 256 : (g == 1) ? 64 : 16;
        localparam logic [31:0] BA = (g == 1) ? 32'h1000 : 32'h0;

        cgra_obi_resp_mem #(
            .DEPTH(DP),
            .BASE_ADDR(BA),
            .GNT_WAIT(GW),
            .READ_LATENCY(RL)
        ) dut (
            .clk_i(clk),
            .rst_ni(rst_n),
            .slave_req_i(rq[g]),
            .slave_resp_o(rs[g])
`ifdef CGRA_OBI_RESP_STATS_EN
            ,
            .rd_cnt_o(rdc[g]),
            .wr_cnt_o(wrc[g]),
            .oor_cnt_o(ooc[g])
`endif
        );

        typedef struct {
            int          due;
            logic [31:0] d;
            logic [31:0] m;
        } exp_t;

        exp_t        q [$];
        exp_t        e;
        logic [31:0] mm [DP];
        logic [3:0]  kn [DP];
        int          hold = 0;
        int          cyc = 0;
        int          k;
        bit          eg;
        bit          inr;
        logic [31:0] a;
        logic [31:0] nrd = 0, nwr = 0, noor = 0;

        initial for (int i = 0; i < DP; i++) kn[i] = 4'h0;

        always @(negedge clk) begin
            cyc++;
            if (!rst_n) begin
                q.delete();
                hold = 0;
                nrd = 0;
                nwr = 0;
                noor = 0;
                chk($sformatf("u%0d rst gnt", g), 32'(rs[g].gnt), 32'd0);
                chk($sformatf("u%0d rst rvalid", g), 32'(rs[g].rvalid), 32'd0);
            end else begin
                // a held request is granted in its (GW+1)th consecutive cycle
                hold = rq[g].req ? hold + 1 : 0;
                eg = (hold == GW + 1);
                chk($sformatf("u%0d gnt", g), 32'(rs[g].gnt), 32'(eg));
                if (eg) begin
                    hold = 0;
                    a = rq[g].addr;
                    inr = (a >= BA) && (((a - BA) >> 2) < 32'(DP));
                    k = inr ? int'((a - BA) >> 2) : 0;
                    if (rq[g].we) begin
                        e = '{cyc + RL, 32'h0, 32'hFFFFFFFF};
                        if (inr) begin
                            for (int b = 0; b < 4; b++) begin
                                if (rq[g].be[b]) begin
                                    mm[k][8*b +: 8] = rq[g].wdata[8*b +: 8];
                                    kn[k][b] = 1'b1;
                                end
                            end
                            nwr++;
                        end else noor++;
                    end else if (inr) begin
                        e = '{cyc + RL, mm[k], bmask(kn[k])};
                        nrd++;
                    end else begin
                        e = '{cyc + RL, 32'hBADCAB1E, 32'hFFFFFFFF};
                        noor++;
                    end
                    q.push_back(e);
                end
                if (q.size() > 0 && q[0].due == cyc) begin
                    e = q.pop_front();
                    chk($sformatf("u%0d rvalid", g), 32'(rs[g].rvalid), 32'd1);
                    chk($sformatf("u%0d rdata", g), rs[g].rdata & e.m, e.d & e.m);
                end else begin
                    chk($sformatf("u%0d idle rvalid", g), 32'(rs[g].rvalid), 32'd0);
                    chk($sformatf("u%0d idle rdata", g), rs[g].rdata, 32'd0);
                end
            end
`ifdef CGRA_OBI_RESP_STATS_EN
            chk($sformatf("u%0d rd_cnt", g), rdc[g], nrd);
            chk($sformatf("u%0d wr_cnt", g), wrc[g], nwr);
            chk($sformatf("u%0d oor_cnt", g), ooc[g], noor);
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int g, input bit r, input bit we, input logic [31:0] a,
                         input logic [3:0] be, input logic [31:0] wd);
        rq[g].req   = r;
        rq[g].we    = we;
        rq[g].addr  = a;
        rq[g].be    = be;
        rq[g].wdata = wd;
    endtask

    task automatic xfer(input int g, input int lat, input bit we, input logic [31:0] a,
                        input logic [3:0] be, input logic [31:0] wd, output logic [31:0] rd);
        int n;
        n = 0;
        rd = 32'h0;
        drive(g, 1'b1, we, a, be, wd);
        #2;
        while (!rs[g].gnt && n < 20) begin
            tick();
            #2;
            n++;
        end
        if (!rs[g].gnt) begin
            chk("gnt timeout", 32'd0, 32'd1);
            drive(g, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
            tick();
            return;
        end
        tick();
        drive(g, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        #2;
        n = 1;
        while (!rs[g].rvalid && n < 10) begin
            tick();
            #2;
            n++;
        end
        chk("latency", n, lat);
        rd = rs[g].rdata;
        tick();
    endtask

    task automatic rand_req(input int g);
        logic [31:0] b, a;
        int          dp;
        bit          r;
        b  = (g == 1) ? 32'h1000 : 32'h0;
        dp = (g == 0) ? 256 : (g == 1) ? 64 : 16;
        if ($urandom_range(0, 1) == 0) a = b + 32'(4 * $urandom_range(0, 7));
        else a = b + 32'(4 * $urandom_range(dp - 2, dp + 1));
        a = a + 32'($urandom_range(0, 3));
        if (g == 1 && $urandom_range(0, 7) == 0) a = b - 32'd4;
        r = (g == 1) ? ($urandom_range(0, 15) != 0) : ($urandom_range(0, 3) != 0);
        drive(g, r, 1'($urandom_range(0, 1)), a, 4'($urandom), $urandom);
    endtask

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t        vt [13];
    logic [31:0] rd;
    logic [31:0] w [3];

    initial begin
        vt = '{
            '{1'b1, 32'h010, 4'hF, 32'hDEADBEEF, 32'h0},
            '{1'b0, 32'h010, 4'h0, 32'h0,        32'hDEADBEEF},
            '{1'b1, 32'h020, 4'hF, 32'h11223344, 32'h0},
            '{1'b1, 32'h020, 4'h5, 32'hAABBCCDD, 32'h0},
            '{1'b0, 32'h020, 4'h0, 32'h0,        32'h11BB33DD},
            '{1'b1, 32'h000, 4'hF, 32'hCAFEF00D, 32'h0},
            '{1'b0, 32'h400, 4'h0, 32'h0,        32'hBADCAB1E},
            '{1'b1, 32'h400, 4'hF, 32'h12345678, 32'h0},
            '{1'b0, 32'h000, 4'h0, 32'h0,        32'hCAFEF00D},
            '{1'b1, 32'h010, 4'h0, 32'hFFFFFFFF, 32'h0},
            '{1'b0, 32'h013, 4'h0, 32'h0,        32'hDEADBEEF},
            '{1'b1, 32'h3FC, 4'hF, 32'h0BADF00D, 32'h0},
            '{1'b0, 32'h3FC, 4'h0, 32'h0,        32'h0BADF00D}
        };
        w = '{32'h01010101, 32'h02020202, 32'h03030303};
        rst_n = 1'b0;
        for (int g = 0; g < N; g++) drive(g, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 13; i++) begin
            xfer(0, 1, vt[i].we, vt[i].addr, vt[i].be, vt[i].wdata, rd);
            chk($sformatf("vec%0d", i), rd, vt[i].exp);
        end
`ifdef CGRA_OBI_RESP_STATS_EN
        chk("oor after table", ooc[0], 32'd2);
`endif

        // wait states: held req granted in cycle 3, rvalid in cycle 5
        drive(1, 1'b1, 1'b0, 32'h1000, 4'hF, 32'h0);
        for (int k = 0; k < 6; k++) begin
            #2;
            chk($sformatf("t3 gnt c%0d", k), 32'(rs[1].gnt), 32'(k == 3));
            chk($sformatf("t3 rvalid c%0d", k), 32'(rs[1].rvalid), 32'(k == 5));
            tick();
            if (k == 3) drive(1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        end
        // dropped req restarts the full wait
        for (int k = 0; k < 6; k++) begin
            drive(1, k != 1, 1'b0, 32'h1004, 4'hF, 32'h0);
            #2;
            chk($sformatf("t3b gnt c%0d", k), 32'(rs[1].gnt), 32'(k == 5));
            tick();
        end
        drive(1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        repeat (4) tick();

        // latency 3, back-to-back in-order reads
        for (int i = 0; i < 3; i++) xfer(2, 3, 1'b1, 32'(4 * i), 4'hF, w[i], rd);
        for (int k = 0; k < 6; k++) begin
            if (k < 3) drive(2, 1'b1, 1'b0, 32'(4 * k), 4'h0, 32'h0);
            else drive(2, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
            #2;
            chk($sformatf("t4 gnt c%0d", k), 32'(rs[2].gnt), 32'(k < 3));
            chk($sformatf("t4 rvalid c%0d", k), 32'(rs[2].rvalid), 32'(k >= 3));
            if (k >= 3) chk($sformatf("t4 rdata c%0d", k), rs[2].rdata, w[k-3]);
            tick();
        end
        repeat (2) tick();

        // reset in the cycle after a read grant discards the response
        drive(1, 1'b1, 1'b0, 32'h1008, 4'hF, 32'h0);
        for (int k = 0; k < 4; k++) begin
            #2;
            chk($sformatf("t6 gnt c%0d", k), 32'(rs[1].gnt), 32'(k == 3));
            tick();
        end
        rst_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            #2;
            chk($sformatf("t6 rst gnt %0d", k), 32'(rs[1].gnt), 32'd0);
            chk($sformatf("t6 rst rvalid %0d", k), 32'(rs[1].rvalid), 32'd0);
            tick();
        end
        rst_n = 1'b1;
        drive(1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        for (int k = 0; k < 4; k++) begin
            #2;
            chk($sformatf("t6 post rvalid %0d", k), 32'(rs[1].rvalid), 32'd0);
`ifdef CGRA_OBI_RESP_STATS_EN
            chk("t6 cnt", rdc[1] | wrc[1] | ooc[1] | rdc[0] | ooc[0], 32'd0);
`endif
            tick();
        end

        for (int c = 0; c < 3000; c++) begin
            for (int g = 0; g < N; g++) rand_req(g);
            tick();
        end
        for (int g = 0; g < N; g++) drive(g, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        repeat (8) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
